ifmap_stream_tx: RTL and testbench
==================================

Name: ifmap_stream_tx

Overview:
- Transmit side of the PE ifmap input buffer interface.
- Reads a rectangular ifmap region from a single-port source memory with 1-cycle read latency.
- Packs PAR_WRITE consecutive pixels into one tagged word per write and pushes each word into the PE ifmap FIFO under its ready/write-enable handshake.
- Tags each pixel with end-of-row and start-of-row flags, which the PE window counters consume.

Parameters:
DATA_WIDTH, 8, pixel width
PAR_WRITE, 2, pixels per pushed word (>=1)
ADDR_WIDTH, 8, source memory address width
LEN_WIDTH, 8, width of row_words / num_rows

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  start-of-transfer pulse, sampled only in IDLE
base_addr  input  ADDR_WIDTH  address of first pixel, captured on accepted start
row_words  input  LEN_WIDTH  words (PAR_WRITE pixels each) per row, captured on start
num_rows  input  LEN_WIDTH  rows to send, captured on start
mem_rd_en  output  1  source memory read strobe
mem_addr  output  ADDR_WIDTH  source memory read address
mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_rd_en
ready_in  input  1  PE ifmap FIFO can accept a word
w_en  output  1  write strobe to PE ifmap FIFO
data_out  output  PAR_WRITE*(DATA_WIDTH+2)  packed word
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse at end of transfer

Behaviour:
- Lane k occupies bits [(k+1)*(DATA_WIDTH+2)-1 : k*(DATA_WIDTH+2)]. Lane 0 holds the lowest-address pixel.
- Within a lane:
  - bit DATA_WIDTH+1 = sor (start-of-row)
  - bit DATA_WIDTH = eor (end-of-row)
  - bits DATA_WIDTH-1:0 = pixel
- sor=1 only on lane 0 of the first word of each row. eor=1 only on lane PAR_WRITE-1 of the last word of each row. All other flag bits are 0. When row_words=1, both flags are set in the same word.
- Reset (async, rst_n=0):
  - state=IDLE
  - mem_rd_en=0, mem_addr=0, w_en=0, data_out=0, busy=0, done=0
  - all counters and lane registers cleared
  - Reset mid-transfer abandons the transfer immediately; no done pulse is generated.
- FSM states: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - start=1 with row_words!=0 and num_rows!=0: capture inputs, pixel pointer=base_addr, go to FETCH.
  - start=1 with row_words=0 or num_rows=0: go directly to DONE.
  - start is ignored in every other state.
- FETCH:
  - Lasts exactly PAR_WRITE cycles.
  - Each cycle: mem_rd_en=1, mem_addr=pointer, pointer increments.
  - Read data is captured into lane (issue index) on the following cycle.
  - After the last issue, go to WAIT.
- WAIT: one cycle; captures the final lane; go to SEND.
- SEND:
  - data_out holds the assembled word with its flags.
  - w_en = ready_in, combinationally gated. A transfer occurs in any SEND cycle with ready_in=1.
  - No transfer: stay in SEND with data_out stable.
  - On transfer, if this was the last word of the last row, go to DONE; otherwise go to FETCH. Word and row counters update on the transfer.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- Timing: the first w_en can occur PAR_WRITE+2 cycles after the start cycle. Steady-state throughput is one word per PAR_WRITE+2 cycles with ready_in held high. FETCH and SEND never overlap.
- Addressing:
  - Rows are contiguous in memory; pixel i is at base_addr+i.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH, with no error indication.
  - Total pixels = row_words*num_rows*PAR_WRITE.
- mem_addr holds its last value when mem_rd_en=0. w_en is never 1 outside SEND.
- Dropping ready_in during SEND only stalls the block; no word is lost or duplicated.

Test Plan:
- Reset/idle: rst_n=0 mid-FETCH -> all outputs 0 immediately. After release with start=0 for 10 cycles -> busy=0, w_en=0.
- Basic: DATA_WIDTH=8, PAR_WRITE=2, base=0x10, row_words=2, num_rows=2, mem[a]=a, ready_in=1 -> 4 words:
  - {sor,0,0x10 | 0,0,0x11}
  - {0,0,0x12 | 0,eor,0x13}
  - {sor,0,0x14 | ...}
  - {... | 0,eor,0x17}
  - First w_en 4 cycles after start, then every 4 cycles; done one cycle after last transfer.
- Backpressure: same setup with ready_in=0 for 5 cycles while word 2 is in SEND -> data_out stable, w_en=0. Word delivered once in the cycle ready_in rises; total of 4 writes.
- Zero length: row_words=0, num_rows=3, start=1 -> no mem_rd_en, no w_en; busy=1 and done=1 in the next cycle only.
- Wrap/single-word rows: ADDR_WIDTH=8, base=0xFE, row_words=1, num_rows=2 -> read addresses FE, FF, 00, 01. Each word carries sor and eor.
- Start while busy: pulse start during SEND with different base -> ignored; original transfer completes unchanged.

Source files
------------

// File: rtl/ifmap_stream_tx.sv
// Reads a rectangular ifmap region from single-port memory and pushes PAR_WRITE-pixel
// words, each lane tagged with start/end-of-row flags, into the PE ifmap FIFO.
module ifmap_stream_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [LEN_WIDTH-1:0]                  row_words,
    input  logic [LEN_WIDTH-1:0]                  num_rows,
    output logic                                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    input  logic                                  ready_in,
    output logic                                  w_en,
    output logic [PAR_WRITE*(DATA_WIDTH+2)-1:0]   data_out,
    output logic                                  busy,
    output logic                                  done
);
    localparam int LANE_W = DATA_WIDTH + 2;
    localparam int IDX_W  = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAR_WRITE - 1);

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, DONE} state_t;
    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  row_words_q, row_words_d, num_rows_q, num_rows_d;
    logic [LEN_WIDTH-1:0]  word_cnt_q, word_cnt_d, row_cnt_q, row_cnt_d;
    logic [IDX_W-1:0]      issue_q, issue_d, cap_idx_q, cap_idx_d;
    logic                  cap_vld_q, cap_vld_d;
    logic [DATA_WIDTH-1:0] lane_q [PAR_WRITE];
    logic [DATA_WIDTH-1:0] lane_d [PAR_WRITE];

    logic start_ok, xfer, last_word, last_row, last_issue;
    logic [PAR_WRITE*LANE_W-1:0] word;

    assign start_ok   = start && (row_words != '0) && (num_rows != '0);
    assign xfer       = (state_q == SEND) && ready_in;
    assign last_word  = (word_cnt_q == row_words_q - LEN_WIDTH'(1));
    assign last_row   = (row_cnt_q == num_rows_q - LEN_WIDTH'(1));
    assign last_issue = (issue_q == LAST_IDX);

    // Each lane captures read data one cycle after its address was issued.
    generate
        for (genvar gi = 0; gi < PAR_WRITE; gi++) begin : g_lane
            assign lane_d[gi] = (cap_vld_q && (cap_idx_q == IDX_W'(gi))) ? mem_rdata : lane_q[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) lane_q[gi] <= '0;
                else        lane_q[gi] <= lane_d[gi];
            end

            assign word[gi*LANE_W +: LANE_W] = {
                (gi == 0) ? (word_cnt_q == '0) : 1'b0,
                (gi == PAR_WRITE - 1) ? last_word : 1'b0,
                lane_q[gi]
            };
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = start_ok ? FETCH : DONE;
            FETCH:   if (last_issue) state_d = WAIT;
            WAIT:    state_d = SEND;
            SEND:    if (xfer) state_d = (last_word && last_row) ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ptr_d       = ptr_q;
        addr_d      = addr_q;
        row_words_d = row_words_q;
        num_rows_d  = num_rows_q;
        word_cnt_d  = word_cnt_q;
        row_cnt_d   = row_cnt_q;
        issue_d     = issue_q;
        cap_vld_d   = (state_q == FETCH);
        cap_idx_d   = issue_q;
        if (state_q == IDLE && start_ok) begin
            ptr_d       = base_addr;
            row_words_d = row_words;
            num_rows_d  = num_rows;
            word_cnt_d  = '0;
            row_cnt_d   = '0;
            issue_d     = '0;
        end
        if (state_q == FETCH) begin
            ptr_d   = ptr_q + ADDR_WIDTH'(1);
            addr_d  = ptr_q;
            issue_d = last_issue ? '0 : issue_q + IDX_W'(1);
        end
        if (xfer) begin
            if (last_word) begin
                word_cnt_d = '0;
                row_cnt_d  = row_cnt_q + LEN_WIDTH'(1);
            end else begin
                word_cnt_d = word_cnt_q + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            addr_q      <= '0;
            row_words_q <= '0;
            num_rows_q  <= '0;
            word_cnt_q  <= '0;
            row_cnt_q   <= '0;
            issue_q     <= '0;
            cap_idx_q   <= '0;
            cap_vld_q   <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            addr_q      <= addr_d;
            row_words_q <= row_words_d;
            num_rows_q  <= num_rows_d;
            word_cnt_q  <= word_cnt_d;
            row_cnt_q   <= row_cnt_d;
            issue_q     <= issue_d;
            cap_idx_q   <= cap_idx_d;
            cap_vld_q   <= cap_vld_d;
        end
    end

    // mem_addr keeps the last issued address whenever no read is in flight.
    always_comb begin
        mem_rd_en = (state_q == FETCH);
        mem_addr  = (state_q == FETCH) ? ptr_q : addr_q;
        w_en      = xfer;
        data_out  = (state_q == SEND) ? word : '0;
        busy      = (state_q != IDLE);
        done      = (state_q == DONE);
    end
endmodule

// File: tb/tb_ifmap_stream_tx.sv
// Bench for ifmap_stream_tx: a transfer-level model predicts every read address, every
// pushed word and the busy/done timeline; directed cases pin the model with literals.
module tb_ifmap_stream_tx;
    localparam int DW   = 8;
    localparam int PW   = 2;
    localparam int AW   = 8;
    localparam int LW   = 8;
    localparam int LANE = DW + 2;
    localparam int WW   = PW * LANE;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] row_words = '0;
    logic [LW-1:0] num_rows = '0;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          ready_in = 1'b0;
    logic          w_en;
    logic [WW-1:0] data_out;
    logic          busy;
    logic          done;

    ifmap_stream_tx #(
        .DATA_WIDTH(DW), .PAR_WRITE(PW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .row_words(row_words), .num_rows(num_rows), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .ready_in(ready_in),
        .w_en(w_en), .data_out(data_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [WW-1:0] exp_word [$];
    logic [AW-1:0] exp_addr [$];
    logic [WW-1:0] wr_data [$];
    int            wr_cyc [$];
    logic [AW-1:0] rd_log [$];
    bit            m_busy = 0;
    bit            m_done = 0;
    bit            m_done_nx = 0;
    int            m_start_cyc = 0;
    int            done_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Model: on an accepted start, lay out the whole transfer as address and word queues.
    initial begin
        logic [WW-1:0] wd;
        logic [AW-1:0] a;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_word.delete();
                exp_addr.delete();
                m_busy = 0;
                m_done = 0;
                m_done_nx = 0;
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                if (done) done_cyc = cyc;
                if (mem_rd_en) begin
                    rd_log.push_back(mem_addr);
                    if (exp_addr.size() == 0) chk("rd_extra", mem_rd_en, 0);
                    else chk("mem_addr", mem_addr, exp_addr.pop_front());
                end
                if (w_en) begin
                    wr_data.push_back(data_out);
                    wr_cyc.push_back(cyc);
                    chk("w_en_ready", w_en, ready_in);
                    if (exp_word.size() == 0) chk("w_extra", w_en, 0);
                    else begin
                        chk("data_out", data_out, exp_word.pop_front());
                        if (exp_word.size() == 0) m_done_nx = 1;
                    end
                end
                if (m_done) m_busy = 0;
                if (!busy && start) begin
                    m_busy = 1;
                    m_start_cyc = cyc;
                    if (row_words == 0 || num_rows == 0) m_done_nx = 1;
                    for (int r = 0; r < int'(num_rows); r++) begin
                        for (int w = 0; w < int'(row_words); w++) begin
                            wd = '0;
                            for (int k = 0; k < PW; k++) begin
                                a = AW'(int'(base_addr) + (r * int'(row_words) + w) * PW + k);
                                exp_addr.push_back(a);
                                wd[k*LANE +: LANE] = {(k == 0 && w == 0),
                                                      (k == PW - 1 && w == int'(row_words) - 1),
                                                      mem[a]};
                            end
                            exp_word.push_back(wd);
                        end
                    end
                end
                m_done = m_done_nx;
                m_done_nx = 0;
            end
        end
    end

    task automatic clear_logs();
        wr_data.delete();
        wr_cyc.delete();
        rd_log.delete();
    endtask

    task automatic start_xfer(input logic [AW-1:0] b, input logic [LW-1:0] rw,
                              input logic [LW-1:0] nr);
        base_addr = b;
        row_words = rw;
        num_rows  = nr;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (busy && n < 3000) begin
            if (rnd) ready_in = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", busy, 0);
        ready_in = 1'b1;
        chk("addr_left", exp_addr.size(), 0);
        chk("words_left", exp_word.size(), 0);
    endtask

    task automatic run_xfer(input logic [AW-1:0] b, input logic [LW-1:0] rw,
                            input logic [LW-1:0] nr, input bit rnd);
        start_xfer(b, rw, nr);
        wait_idle(rnd);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_w_en", w_en, 0);
        chk("rst_data", data_out, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_addr", mem_addr, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic 2x2 transfer, mem[a]=a
        clear_logs();
        run_xfer(8'h10, 2, 2, 0);
        chk("basic_nwr", wr_data.size(), 4);
        if (wr_data.size() == 4) begin
            chk("basic_w0", wr_data[0], 20'h04610);
            chk("basic_w1", wr_data[1], 20'h44C12);
            chk("basic_w2", wr_data[2], 20'h05614);
            chk("basic_w3", wr_data[3], 20'h45C16);
            chk("basic_lat", wr_cyc[0] - m_start_cyc, 4);
            for (int i = 1; i < 4; i++) chk("basic_period", wr_cyc[i] - wr_cyc[i-1], 4);
            chk("basic_done", done_cyc - wr_cyc[3], 1);
        end

        // Backpressure on word 1
        clear_logs();
        start_xfer(8'h10, 2, 2);
        n = 0;
        while (wr_data.size() < 1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bp_first_wait", wr_data.size(), 1);
        ready_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stable", data_out, 20'h44C12);
            chk("bp_wen", w_en, 0);
            @(posedge clk); #1;
        end
        ready_in = 1'b1;
        wait_idle(0);
        chk("bp_nwr", wr_data.size(), 4);
        if (wr_data.size() == 4) begin
            chk("bp_w1", wr_data[1], 20'h44C12);
            chk("bp_w1_cyc", wr_cyc[1] - m_start_cyc, 13);
        end

        // Zero-length request
        clear_logs();
        run_xfer(8'h40, 0, 3, 0);
        chk("zero_nwr", wr_data.size(), 0);
        chk("zero_nrd", rd_log.size(), 0);
        chk("zero_done", done_cyc - m_start_cyc, 1);

        // Address wrap with single-word rows
        clear_logs();
        run_xfer(8'hFE, 1, 2, 0);
        chk("wrap_nrd", rd_log.size(), 4);
        if (rd_log.size() == 4) begin
            chk("wrap_a0", rd_log[0], 8'hFE);
            chk("wrap_a1", rd_log[1], 8'hFF);
            chk("wrap_a2", rd_log[2], 8'h00);
            chk("wrap_a3", rd_log[3], 8'h01);
        end
        chk("wrap_nwr", wr_data.size(), 2);
        if (wr_data.size() == 2) begin
            chk("wrap_w0", wr_data[0], 20'h7FEFE);
            chk("wrap_w1", wr_data[1], 20'h40600);
        end

        // Start pulsed while busy is ignored
        clear_logs();
        start_xfer(8'h20, 2, 1);
        repeat (3) @(posedge clk);
        #1;
        base_addr = 8'h80;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle(0);
        chk("sb_nwr", wr_data.size(), 2);
        chk("sb_nrd", rd_log.size(), 4);
        if (wr_data.size() == 2) begin
            chk("sb_w0", wr_data[0], 20'h08620);
            chk("sb_w1", wr_data[1], 20'h48C22);
        end

        // Reset during FETCH
        clear_logs();
        start_xfer(8'h30, 3, 2);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rd_en", mem_rd_en, 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_w_en", w_en, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("post_rst_busy", busy, 0);
            chk("post_rst_w_en", w_en, 0);
        end

        // Randomized transfers with random backpressure
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom());
            clear_logs();
            run_xfer(AW'($urandom()), LW'($urandom_range(0, 4)), LW'($urandom_range(0, 3)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
